// File: rtl/immediate_encoder.sv
// Packs a 64-bit immediate into the I/S/B/U/J fields of a RISC-V instruction word, behind a 2-entry output buffer.
// Optional build macro IMMENC_RANGE_CHECK_EN also flags immediates that do not fit (or are misaligned for) the chosen format.
module immediate_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [2:0]           immType,
    input  logic [63:0]          imm64,
    input  logic [31:0]          baseInst,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [31:0]          encInst,
    output logic                 immErr,
    output logic [ERR_CNT_W-1:0] errCnt
);

    logic [31:0] enc_inst;
    logic        enc_err;
    logic        range_bad;

`ifdef IMMENC_RANGE_CHECK_EN
    // A field fits when every bit above its sign position equals that sign bit.
    logic fits_11, fits_12, fits_20, fits_31;
    assign fits_11 = (&imm64[63:11]) || !(|imm64[63:11]);
    assign fits_12 = (&imm64[63:12]) || !(|imm64[63:12]);
    assign fits_20 = (&imm64[63:20]) || !(|imm64[63:20]);
    assign fits_31 = (&imm64[63:31]) || !(|imm64[63:31]);
`endif

    always_comb begin
        enc_inst  = baseInst;
        enc_err   = 1'b0;
        range_bad = 1'b0;
        case (immType)
            3'b000: begin
                enc_inst[31:20] = imm64[11:0];
`ifdef IMMENC_RANGE_CHECK_EN
                range_bad = !fits_11;
`endif
            end
            3'b001: begin
                enc_inst[31:25] = imm64[11:5];
                enc_inst[11:7]  = imm64[4:0];
`ifdef IMMENC_RANGE_CHECK_EN
                range_bad = !fits_11;
`endif
            end
            3'b010: begin
                enc_inst[31]    = imm64[12];
                enc_inst[30:25] = imm64[10:5];
                enc_inst[11:8]  = imm64[4:1];
                enc_inst[7]     = imm64[11];
`ifdef IMMENC_RANGE_CHECK_EN
                range_bad = !fits_12 || imm64[0];
`endif
            end
            3'b011: begin
                enc_inst[31:12] = imm64[31:12];
`ifdef IMMENC_RANGE_CHECK_EN
                range_bad = !fits_31 || (imm64[11:0] != 12'd0);
`endif
            end
            3'b100: begin
                enc_inst[31]    = imm64[20];
                enc_inst[30:21] = imm64[10:1];
                enc_inst[20]    = imm64[11];
                enc_inst[19:12] = imm64[19:12];
`ifdef IMMENC_RANGE_CHECK_EN
                range_bad = !fits_20 || imm64[0];
`endif
            end
            default: enc_err = 1'b1;
        endcase
        enc_err = enc_err || range_bad;
    end

    // Two-slot buffer: slot0 is the head and is left untouched on the final pop,
    // so the outputs keep showing the last consumed entry while empty.
    logic [31:0] slot0_inst, slot1_inst;
    logic        slot0_err, slot1_err;
    logic [1:0]  count, count_next;
    logic        ready_q;
    logic        push, pop;

    assign outValid = (count != 2'd0);
    assign inReady  = ready_q;
    assign encInst  = slot0_inst;
    assign immErr   = slot0_err;
    assign push     = inValid && ready_q;
    assign pop      = outValid && outReady;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count      <= 2'd0;
            ready_q    <= 1'b1;
            slot0_inst <= 32'd0;
            slot0_err  <= 1'b0;
            slot1_inst <= 32'd0;
            slot1_err  <= 1'b0;
            errCnt     <= '0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (count == 2'd2 && pop) begin
                slot0_inst <= slot1_inst;
                slot0_err  <= slot1_err;
            end else if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                slot0_inst <= enc_inst;
                slot0_err  <= enc_err;
            end
            if (push && count == 2'd1 && !pop) begin
                slot1_inst <= enc_inst;
                slot1_err  <= enc_err;
            end
            if (push && enc_err && (errCnt != {ERR_CNT_W{1'b1}})) begin
                errCnt <= errCnt + 1'b1;
            end
        end
    end

endmodule
